// File: rtl/grid_world_mem.sv
// grid_world_mem: self-initialising GRID_W x GRID_H cell store with one
// registered read port, one write port that returns the previous cell
// contents, and a live count of snake cells. After reset or clear it walks
// every address once to load the starting board before accepting requests.
module grid_world_mem #(
    parameter int GRID_W    = 15,
    parameter int GRID_H    = 15,
    parameter int CELL_BITS = 2,
    parameter int X_BITS    = 4,
    parameter int Y_BITS    = 4,
    parameter int INIT_LEN  = 3,
    parameter int FOOD_X    = 3,
    parameter int FOOD_Y    = 3,
    localparam int CNT_W    = $clog2(GRID_W * GRID_H + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    output logic                 init_busy,
    input  logic                 rd_en,
    input  logic [X_BITS-1:0]    rd_x,
    input  logic [Y_BITS-1:0]    rd_y,
    output logic [CELL_BITS-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 wr_en,
    input  logic [X_BITS-1:0]    wr_x,
    input  logic [Y_BITS-1:0]    wr_y,
    input  logic [CELL_BITS-1:0] wr_data,
    output logic [CELL_BITS-1:0] wr_prev,
    output logic                 wr_prev_valid,
    output logic                 oob_err,
    output logic [CNT_W-1:0]     snake_count
);

    localparam int DEPTH     = GRID_W * GRID_H;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int FOOD_ADDR = FOOD_Y * GRID_W + FOOD_X;

    localparam logic [CELL_BITS-1:0] CELL_EMPTY = CELL_BITS'(2'b00);
    localparam logic [CELL_BITS-1:0] CELL_FOOD  = CELL_BITS'(2'b01);
    localparam logic [CELL_BITS-1:0] CELL_SNAKE = CELL_BITS'(2'b10);
    localparam logic [ADDR_W-1:0]    LAST_ADDR  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state_r;
    logic [ADDR_W-1:0]      addr_r;
    logic [CELL_BITS-1:0]   mem [DEPTH];

    logic                   rd_oob_s;
    logic                   wr_oob_s;
    logic                   wr_ok_s;
    logic [ADDR_W-1:0]      rd_addr_s;
    logic [ADDR_W-1:0]      wr_addr_s;
    logic [CELL_BITS-1:0]   rd_cell_s;
    logic [CELL_BITS-1:0]   wr_old_s;
    logic [CNT_W-1:0]       snake_next_s;
    logic                   mem_we_s;
    logic [ADDR_W-1:0]      mem_waddr_s;
    logic [CELL_BITS-1:0]   mem_wdata_s;

    // Starting board: snake along the top row, one food cell, rest empty.
    function automatic logic [CELL_BITS-1:0] init_cell(input logic [ADDR_W-1:0] a);
        logic [CELL_BITS-1:0] c;
        if (int'(a) < INIT_LEN) begin
            c = CELL_SNAKE;
        end else if (int'(a) == FOOD_ADDR) begin
            c = CELL_FOOD;
        end else begin
            c = CELL_EMPTY;
        end
        return c;
    endfunction

    assign rd_oob_s  = (int'(rd_x) >= GRID_W) || (int'(rd_y) >= GRID_H);
    assign wr_oob_s  = (int'(wr_x) >= GRID_W) || (int'(wr_y) >= GRID_H);
    assign wr_ok_s   = wr_en && !wr_oob_s;
    assign rd_addr_s = ADDR_W'(int'(rd_y) * GRID_W + int'(rd_x));
    assign wr_addr_s = ADDR_W'(int'(wr_y) * GRID_W + int'(wr_x));
    // Out-of-range addresses never index the array.
    assign rd_cell_s = rd_oob_s ? CELL_EMPTY : mem[rd_addr_s];
    assign wr_old_s  = wr_oob_s ? CELL_EMPTY : mem[wr_addr_s];

    // Snake counter adjustment from the old and new contents of the written cell.
    always_comb begin
        snake_next_s = snake_count;
        if (wr_ok_s && (wr_old_s == CELL_SNAKE) && (wr_data != CELL_SNAKE)) begin
            snake_next_s = snake_count - CNT_W'(1);
        end else if (wr_ok_s && (wr_old_s != CELL_SNAKE) && (wr_data == CELL_SNAKE)) begin
            snake_next_s = snake_count + CNT_W'(1);
        end else begin
            snake_next_s = snake_count;
        end
    end

    // Array write port: init walk owns it in INIT, the request port in READY.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = addr_r;
        mem_wdata_s = init_cell(addr_r);
        if (rst) begin
            mem_we_s = 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    mem_we_s = 1'b1;
                end
                ST_READY: begin
                    mem_we_s    = wr_ok_s;
                    mem_waddr_s = wr_addr_s;
                    mem_wdata_s = wr_data;
                end
                default: begin
                    mem_we_s = 1'b0;
                end
            endcase
        end
    end

    // Cell storage; no reset so it maps onto RAM, the init walk fills it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control FSM with registered read, write-previous and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_INIT;
            addr_r        <= {ADDR_W{1'b0}};
            init_busy     <= 1'b1;
            rd_data       <= CELL_EMPTY;
            rd_valid      <= 1'b0;
            wr_prev       <= CELL_EMPTY;
            wr_prev_valid <= 1'b0;
            oob_err       <= 1'b0;
            snake_count   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    rd_valid      <= 1'b0;
                    wr_prev_valid <= 1'b0;
                    oob_err       <= 1'b0;
                    if (addr_r == LAST_ADDR) begin
                        state_r     <= ST_READY;
                        addr_r      <= {ADDR_W{1'b0}};
                        init_busy   <= 1'b0;
                        snake_count <= CNT_W'(INIT_LEN);
                    end else begin
                        addr_r    <= addr_r + ADDR_W'(1);
                        init_busy <= 1'b1;
                    end
                end
                ST_READY: begin
                    rd_valid      <= rd_en;
                    wr_prev_valid <= wr_ok_s;
                    oob_err       <= (rd_en && rd_oob_s) || (wr_en && wr_oob_s);
                    snake_count   <= snake_next_s;
                    if (rd_en) begin
                        rd_data <= rd_cell_s;
                    end
                    if (wr_ok_s) begin
                        wr_prev <= wr_old_s;
                    end
                    // Requests in the clear cycle are serviced before re-init.
                    if (clear) begin
                        state_r   <= ST_INIT;
                        addr_r    <= {ADDR_W{1'b0}};
                        init_busy <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_INIT;
                    addr_r    <= {ADDR_W{1'b0}};
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_world_mem.sv
// Self-checking bench for grid_world_mem: directed scenarios plus a
// randomized read/write stream checked against a board model.
module tb_grid_world_mem;

    localparam int GW    = 15;
    localparam int GH    = 15;
    localparam int DEPTH = GW * GH;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       init_busy;
    logic       rd_en = 1'b0;
    logic [3:0] rd_x = 4'd0;
    logic [3:0] rd_y = 4'd0;
    logic [1:0] rd_data;
    logic       rd_valid;
    logic       wr_en = 1'b0;
    logic [3:0] wr_x = 4'd0;
    logic [3:0] wr_y = 4'd0;
    logic [1:0] wr_data = 2'd0;
    logic [1:0] wr_prev;
    logic       wr_prev_valid;
    logic       oob_err;
    logic [7:0] snake_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0] model [DEPTH];

    always #5 clk = ~clk;

    grid_world_mem dut (
        .clk(clk), .rst(rst), .clear(clear), .init_busy(init_busy),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_prev(wr_prev), .wr_prev_valid(wr_prev_valid), .oob_err(oob_err),
        .snake_count(snake_count)
    );

    function automatic int cell_addr(input int x, input int y);
        return y * GW + x;
    endfunction

    function automatic bit in_range(input int x, input int y);
        return (x < GW) && (y < GH);
    endfunction

    function automatic int model_snakes();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (model[i] == 2'b10) n++;
        return n;
    endfunction

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 3) model[i] = 2'b10;
            else if (i == cell_addr(3, 3)) model[i] = 2'b01;
            else model[i] = 2'b00;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; wr_en = 1'b0; clear = 1'b0;
    endtask

    task automatic drive(input bit re, input int rx, input int ry,
                         input bit we, input int wx, input int wy,
                         input int wd, input bit clr);
        rd_en = re; rd_x = 4'(rx); rd_y = 4'(ry);
        wr_en = we; wr_x = 4'(wx); wr_y = 4'(wy); wr_data = 2'(wd);
        clear = clr;
        tick();
        idle_inputs();
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run += 7;
        if (init_busy !== 1'b1) begin tests_failed++; $display("FAIL rst_init_busy: got %b expected 1", init_busy); end
        if (rd_data !== 2'b00) begin tests_failed++; $display("FAIL rst_rd_data: got %b expected 00", rd_data); end
        if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
        if (wr_prev !== 2'b00) begin tests_failed++; $display("FAIL rst_wr_prev: got %b expected 00", wr_prev); end
        if (wr_prev_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_wr_prev_valid: got %b expected 0", wr_prev_valid); end
        if (oob_err !== 1'b0) begin tests_failed++; $display("FAIL rst_oob_err: got %b expected 0", oob_err); end
        if (snake_count !== 8'd0) begin tests_failed++; $display("FAIL rst_snake_count: got %0d expected 0", snake_count); end
        wait_init(n);
        tests_run++;
        if (n != DEPTH) begin tests_failed++; $display("FAIL init_length: got %0d cycles expected %0d", n, DEPTH); end
        model_init();
    endtask

    task automatic test_init_contents();
        int xs [4] = '{0, 2, 3, 3};
        int ys [4] = '{0, 0, 0, 3};
        logic [1:0] exp [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, xs[i], ys[i], 1'b0, 0, 0, 0, 1'b0);
            tests_run += 2;
            if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL init_rd_valid(%0d,%0d): got %b expected 1", xs[i], ys[i], rd_valid); end
            if (rd_data !== exp[i]) begin tests_failed++; $display("FAIL init_cell(%0d,%0d): got %b expected %b", xs[i], ys[i], rd_data, exp[i]); end
        end
        tests_run++;
        if (snake_count !== 8'd3) begin tests_failed++; $display("FAIL init_snake_count: got %0d expected 3", snake_count); end
    endtask

    task automatic test_write_prev();
        drive(1'b0, 0, 0, 1'b1, 3, 3, 2, 1'b0);
        model[cell_addr(3, 3)] = 2'b10;
        tests_run += 3;
        if (wr_prev !== 2'b01) begin tests_failed++; $display("FAIL wp1_prev: got %b expected 01", wr_prev); end
        if (wr_prev_valid !== 1'b1) begin tests_failed++; $display("FAIL wp1_valid: got %b expected 1", wr_prev_valid); end
        if (snake_count !== 8'd4) begin tests_failed++; $display("FAIL wp1_snake: got %0d expected 4", snake_count); end
        drive(1'b0, 0, 0, 1'b1, 0, 0, 0, 1'b0);
        model[cell_addr(0, 0)] = 2'b00;
        tests_run += 2;
        if (wr_prev !== 2'b10) begin tests_failed++; $display("FAIL wp2_prev: got %b expected 10", wr_prev); end
        if (snake_count !== 8'd3) begin tests_failed++; $display("FAIL wp2_snake: got %0d expected 3", snake_count); end
        tick();
        tests_run++;
        if (wr_prev_valid !== 1'b0) begin tests_failed++; $display("FAIL wp_pulse: got %b expected 0", wr_prev_valid); end
    endtask

    task automatic test_read_first();
        drive(1'b1, 5, 5, 1'b1, 5, 5, 1, 1'b0);
        model[cell_addr(5, 5)] = 2'b01;
        tests_run += 2;
        if (rd_data !== 2'b00) begin tests_failed++; $display("FAIL rf_old: got %b expected 00", rd_data); end
        if (wr_prev_valid !== 1'b1) begin tests_failed++; $display("FAIL rf_wp_valid: got %b expected 1", wr_prev_valid); end
        drive(1'b1, 5, 5, 1'b0, 0, 0, 0, 1'b0);
        tests_run++;
        if (rd_data !== 2'b01) begin tests_failed++; $display("FAIL rf_new: got %b expected 01", rd_data); end
    endtask

    task automatic test_oob();
        int s = model_snakes();
        drive(1'b1, 15, 0, 1'b0, 0, 0, 0, 1'b0);
        tests_run += 3;
        if (oob_err !== 1'b1) begin tests_failed++; $display("FAIL oob_rd_err: got %b expected 1", oob_err); end
        if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL oob_rd_valid: got %b expected 1", rd_valid); end
        if (rd_data !== 2'b00) begin tests_failed++; $display("FAIL oob_rd_data: got %b expected 00", rd_data); end
        tick();
        tests_run += 2;
        if (oob_err !== 1'b0) begin tests_failed++; $display("FAIL oob_pulse: got %b expected 0", oob_err); end
        if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
        drive(1'b0, 0, 0, 1'b1, 0, 15, 2, 1'b0);
        tests_run += 3;
        if (oob_err !== 1'b1) begin tests_failed++; $display("FAIL oob_wr_err: got %b expected 1", oob_err); end
        if (wr_prev_valid !== 1'b0) begin tests_failed++; $display("FAIL oob_wr_valid: got %b expected 0", wr_prev_valid); end
        if (snake_count !== 8'(s)) begin tests_failed++; $display("FAIL oob_wr_snake: got %0d expected %0d", snake_count, s); end
    endtask

    task automatic test_random();
        logic [1:0] exp_rd   = 2'b00;
        logic [1:0] exp_prev = 2'b00;
        for (int i = 0; i < 400; i++) begin
            bit re, we, rok, wok, exp_oob;
            int rx, ry, wx, wy, wd;
            re = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
            rx = $urandom_range(0, 15); ry = $urandom_range(0, 15);
            wx = $urandom_range(0, 15); wy = $urandom_range(0, 15);
            wd = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin wx = rx; wy = ry; end
            if (i == 0) begin re = 1'b1; we = 1'b1; rx = 1; ry = 1; wx = 2; wy = 2; end
            rok = in_range(rx, ry);
            wok = in_range(wx, wy);
            if (re) exp_rd = rok ? model[cell_addr(rx, ry)] : 2'b00;
            if (we && wok) exp_prev = model[cell_addr(wx, wy)];
            exp_oob = (re && !rok) || (we && !wok);
            drive(re, rx, ry, we, wx, wy, wd, 1'b0);
            if (we && wok) model[cell_addr(wx, wy)] = 2'(wd);
            tests_run += 6;
            if (rd_valid !== re) begin tests_failed++; $display("FAIL rnd_rd_valid[%0d]: got %b expected %b", i, rd_valid, re); end
            if (rd_data !== exp_rd) begin tests_failed++; $display("FAIL rnd_rd_data[%0d]: got %b expected %b", i, rd_data, exp_rd); end
            if (wr_prev_valid !== (we && wok)) begin tests_failed++; $display("FAIL rnd_wp_valid[%0d]: got %b expected %b", i, wr_prev_valid, we && wok); end
            if (wr_prev !== exp_prev) begin tests_failed++; $display("FAIL rnd_wr_prev[%0d]: got %b expected %b", i, wr_prev, exp_prev); end
            if (oob_err !== exp_oob) begin tests_failed++; $display("FAIL rnd_oob[%0d]: got %b expected %b", i, oob_err, exp_oob); end
            if (snake_count !== 8'(model_snakes())) begin tests_failed++; $display("FAIL rnd_snake[%0d]: got %0d expected %0d", i, snake_count, model_snakes()); end
        end
    endtask

    task automatic test_ignored_during_init();
        int n = 0;
        int pulses = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        while (init_busy === 1'b1 && n < 1000) begin
            wr_en = 1'b1; wr_x = 4'd7; wr_y = 4'd7; wr_data = 2'b10;
            rd_en = 1'b1;
            rd_x = (n % 2 == 0) ? 4'd15 : 4'd7;
            rd_y = (n % 2 == 0) ? 4'd15 : 4'd7;
            clear = (n % 3 == 0);
            tick();
            n++;
            if (rd_valid !== 1'b0 || oob_err !== 1'b0 || wr_prev_valid !== 1'b0) pulses++;
        end
        idle_inputs();
        model_init();
        tests_run += 2;
        if (pulses != 0) begin tests_failed++; $display("FAIL init_pulses: got %0d expected 0", pulses); end
        if (n != DEPTH) begin tests_failed++; $display("FAIL init_ignore_len: got %0d expected %0d", n, DEPTH); end
        drive(1'b1, 7, 7, 1'b0, 0, 0, 0, 1'b0);
        tests_run += 2;
        if (rd_data !== 2'b00) begin tests_failed++; $display("FAIL init_ignore_cell: got %b expected 00", rd_data); end
        if (snake_count !== 8'd3) begin tests_failed++; $display("FAIL init_ignore_snake: got %0d expected 3", snake_count); end
    endtask

    task automatic test_reset_mid_init();
        int n;
        int xs [3] = '{1, 3, 14};
        int ys [3] = '{0, 3, 14};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init(n);
        tests_run++;
        if (n != DEPTH) begin tests_failed++; $display("FAIL mid_rst_len: got %0d expected %0d", n, DEPTH); end
        model_init();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, xs[i], ys[i], 1'b0, 0, 0, 0, 1'b0);
            tests_run++;
            if (rd_data !== model[cell_addr(xs[i], ys[i])]) begin
                tests_failed++;
                $display("FAIL mid_rst_cell(%0d,%0d): got %b expected %b", xs[i], ys[i], rd_data, model[cell_addr(xs[i], ys[i])]);
            end
        end
    endtask

    task automatic test_clear();
        int n;
        int bad = 0;
        logic [1:0] exp_prev;
        for (int i = 0; i < 30; i++) begin
            int x = $urandom_range(0, GW - 1);
            int y = $urandom_range(0, GH - 1);
            int d = $urandom_range(0, 3);
            drive(1'b0, 0, 0, 1'b1, x, y, d, 1'b0);
            model[cell_addr(x, y)] = 2'(d);
        end
        exp_prev = model[cell_addr(4, 4)];
        drive(1'b0, 0, 0, 1'b1, 4, 4, 2, 1'b1);
        tests_run += 3;
        if (wr_prev_valid !== 1'b1) begin tests_failed++; $display("FAIL clr_wp_valid: got %b expected 1", wr_prev_valid); end
        if (wr_prev !== exp_prev) begin tests_failed++; $display("FAIL clr_wr_prev: got %b expected %b", wr_prev, exp_prev); end
        if (init_busy !== 1'b1) begin tests_failed++; $display("FAIL clr_busy: got %b expected 1", init_busy); end
        wait_init(n);
        tests_run++;
        if (n != DEPTH) begin tests_failed++; $display("FAIL clr_len: got %0d expected %0d", n, DEPTH); end
        model_init();
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                drive(1'b1, x, y, 1'b0, 0, 0, 0, 1'b0);
                if (rd_data !== model[cell_addr(x, y)]) begin
                    bad++;
                    $display("FAIL clr_cell(%0d,%0d): got %b expected %b", x, y, rd_data, model[cell_addr(x, y)]);
                end
            end
        end
        tests_run += 2;
        if (bad != 0) tests_failed++;
        if (snake_count !== 8'd3) begin tests_failed++; $display("FAIL clr_snake: got %0d expected 3", snake_count); end
    endtask

    initial begin
        test_reset();
        test_init_contents();
        test_write_prev();
        test_read_first();
        test_oob();
        test_random();
        test_ignored_during_init();
        test_reset_mid_init();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
